// File: rtl/gb_host_arbiter.sv
// rtl/gb_host_arbiter.sv - two-requester round-robin ghostbus host arbiter
// Single-beat transactions; read data is captured a fixed RD_LAT cycles after the read strobe.
module gb_host_arbiter #(
   parameter int AW     = 24,
   parameter int DW     = 32,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_done,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_done,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] gb_addr,
   output logic [DW-1:0] gb_wdata,
   output logic          gb_we,
   output logic          gb_re,
   input  logic [DW-1:0] gb_rdata,
   output logic          busy,
   output logic          last_grant
);

   localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic          gnt_q, gnt_d;
   logic          last_grant_q, last_grant_d;
   logic [AW-1:0] gb_addr_q, gb_addr_d;
   logic [DW-1:0] gb_wdata_q, gb_wdata_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         gnt_q        <= 1'b0;
         last_grant_q <= 1'b1;
         gb_addr_q    <= '0;
         gb_wdata_q   <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         gb_addr_q    <= gb_addr_d;
         gb_wdata_q   <= gb_wdata_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      gb_addr_d    = gb_addr_q;
      gb_wdata_d   = gb_wdata_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               // On a tie the requester not served last wins; otherwise the lone requester.
               gnt_d        = (m0_req && m1_req) ? ~last_grant_q : m1_req;
               we_d         = gnt_d ? m1_we    : m0_we;
               gb_addr_d    = gnt_d ? m1_addr  : m0_addr;
               gb_wdata_d   = gnt_d ? m1_wdata : m0_wdata;
               last_grant_d = gnt_d;
               state_d      = STROBE;
            end
         end
         STROBE: begin
            if (we_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = RD_LAT_C;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (gnt_q) m1_rdata_d = gb_rdata;
               else       m0_rdata_d = gb_rdata;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign gb_we      = (state_q == STROBE) && we_q;
   assign gb_re      = (state_q == STROBE) && !we_q;
   assign m0_done    = (state_q == DONE) && !gnt_q;
   assign m1_done    = (state_q == DONE) && gnt_q;
   assign busy       = (state_q != IDLE);
   assign last_grant = last_grant_q;
   assign gb_addr    = gb_addr_q;
   assign gb_wdata   = gb_wdata_q;
   assign m0_rdata   = m0_rdata_q;
   assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_gb_host_arbiter.sv
// tb/tb_gb_host_arbiter.sv - self-checking bench for gb_host_arbiter
// Instance u0 uses RD_LAT=2 with a scoreboard monitor; instance l1 uses RD_LAT=1.
module tb_gb_host_arbiter;

   localparam int L0 = 2;
   localparam int L1 = 1;

   typedef struct {
      bit          port;
      bit          we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          t_strobe;
   } exp_t;

   typedef struct {
      bit          port;
      bit          we;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          exp_lg;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic        u0_m0_req = 0, u0_m0_we = 0, u0_m1_req = 0, u0_m1_we = 0;
   logic [23:0] u0_m0_addr = 0, u0_m1_addr = 0;
   logic [31:0] u0_m0_wdata = 0, u0_m1_wdata = 0, u0_gb_rdata = 0;
   logic        u0_m0_done, u0_m1_done, u0_gb_we, u0_gb_re, u0_busy, u0_last_grant;
   logic [31:0] u0_m0_rdata, u0_m1_rdata, u0_gb_wdata;
   logic [23:0] u0_gb_addr;

   logic        l1_m0_req = 0;
   logic [31:0] l1_gb_rdata = 0;
   logic        l1_m0_done, l1_m1_done, l1_gb_we, l1_gb_re, l1_busy, l1_last_grant;
   logic [31:0] l1_m0_rdata, l1_m1_rdata, l1_gb_wdata;
   logic [23:0] l1_gb_addr;

   exp_t        sb[$];
   exp_t        em;
   logic [31:0] exp_rd [2] = '{32'h0, 32'h0};
   int          strobe_cyc = 0;
   bit          u0_pend = 0, l1_pend = 0;
   int          u0_due = 0, l1_due = 0;
   logic [31:0] u0_val = 0, l1_val = 0;

   gb_host_arbiter #(.AW(24), .DW(32), .RD_LAT(L0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(u0_m0_req), .m0_we(u0_m0_we), .m0_addr(u0_m0_addr), .m0_wdata(u0_m0_wdata),
      .m0_done(u0_m0_done), .m0_rdata(u0_m0_rdata),
      .m1_req(u0_m1_req), .m1_we(u0_m1_we), .m1_addr(u0_m1_addr), .m1_wdata(u0_m1_wdata),
      .m1_done(u0_m1_done), .m1_rdata(u0_m1_rdata),
      .gb_addr(u0_gb_addr), .gb_wdata(u0_gb_wdata), .gb_we(u0_gb_we), .gb_re(u0_gb_re),
      .gb_rdata(u0_gb_rdata), .busy(u0_busy), .last_grant(u0_last_grant)
   );

   gb_host_arbiter #(.AW(24), .DW(32), .RD_LAT(L1)) l1 (
      .clk(clk), .rst_n(rst_n),
      .m0_req(l1_m0_req), .m0_we(1'b0), .m0_addr(24'h00003C), .m0_wdata(32'h0),
      .m0_done(l1_m0_done), .m0_rdata(l1_m0_rdata),
      .m1_req(1'b0), .m1_we(1'b0), .m1_addr(24'h0), .m1_wdata(32'h0),
      .m1_done(l1_m1_done), .m1_rdata(l1_m1_rdata),
      .gb_addr(l1_gb_addr), .gb_wdata(l1_gb_wdata), .gb_we(l1_gb_we), .gb_re(l1_gb_re),
      .gb_rdata(l1_gb_rdata), .busy(l1_busy), .last_grant(l1_last_grant)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t mk(bit port, bit we, logic [23:0] addr, logic [31:0] wdata,
                               logic [31:0] rdata, int t_strobe);
      exp_t e;
      e.port = port; e.we = we; e.addr = addr; e.wdata = wdata;
      e.rdata = rdata; e.t_strobe = t_strobe;
      return e;
   endfunction

   task automatic drive(input bit port, input logic req, input logic we,
                        input logic [23:0] addr, input logic [31:0] wdata);
      if (port) begin
         u0_m1_req = req; u0_m1_we = we; u0_m1_addr = addr; u0_m1_wdata = wdata;
      end else begin
         u0_m0_req = req; u0_m0_we = we; u0_m0_addr = addr; u0_m0_wdata = wdata;
      end
   endtask

   task automatic wait_strobe();
      bit ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (u0_gb_we || u0_gb_re) begin ok = 1; break; end
      end
      chk("strobe_seen", ok, 1);
   endtask

   // Cycle counter and read-data responders; off-slot cycles carry junk data.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (u0_pend && cyc == u0_due) begin u0_gb_rdata = u0_val; u0_pend = 0; end
      else u0_gb_rdata = 32'hBAD0_0000 ^ 32'(cyc);
      if (l1_pend && cyc == l1_due) begin l1_gb_rdata = l1_val; l1_pend = 0; end
      else l1_gb_rdata = 32'hBAD1_0000 ^ 32'(cyc);
   end

   always @(negedge clk) begin
      if (l1_gb_re) begin
         l1_pend = 1; l1_due = cyc + L1; l1_val = 32'hC0DE_0000 ^ 32'(cyc);
      end
   end

   always @(negedge clk) begin
      chk("we_re_excl", u0_gb_we & u0_gb_re, 0);
      chk("done_excl", u0_m0_done & u0_m1_done, 0);
      if (u0_gb_we || u0_gb_re) begin
         chk("sb_pending_at_strobe", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            em = sb[0];
            chk("strobe_we", u0_gb_we, em.we);
            chk("strobe_re", u0_gb_re, !em.we);
            chk("gb_addr", u0_gb_addr, em.addr);
            chk("gb_wdata", u0_gb_wdata, em.wdata);
            chk("last_grant_at_strobe", u0_last_grant, em.port);
            chk("busy_at_strobe", u0_busy, 1);
            if (em.t_strobe >= 0) chk("strobe_cycle", cyc, em.t_strobe);
            strobe_cyc = cyc;
            if (!em.we) begin u0_pend = 1; u0_due = cyc + L0; u0_val = em.rdata; end
         end
      end
      if (u0_m0_done || u0_m1_done) begin
         chk("sb_pending_at_done", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            em = sb.pop_front();
            chk("done_port", u0_m1_done, em.port);
            chk("done_latency", cyc - strobe_cyc, em.we ? 1 : 1 + L0);
            chk("busy_at_done", u0_busy, 1);
            if (!em.we) exp_rd[em.port] = em.rdata;
            chk("m0_rdata", u0_m0_rdata, exp_rd[0]);
            chk("m1_rdata", u0_m1_rdata, exp_rd[1]);
         end
      end
   end

   initial begin
      vec_t vecs [7];
      int   t, n, ns, nd;
      int   st [4];
      int   dn [4];
      bit   ok;

      vecs[0] = '{1'b0, 1'b1, 24'h000010, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1] = '{1'b1, 1'b0, 24'h000040, 32'h0,        32'h5,        1'b1};
      vecs[2] = '{1'b0, 1'b0, 24'h000123, 32'h1111,     32'h12345678, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 24'hFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1};
      vecs[4] = '{1'b0, 1'b1, 24'h000000, 32'h0,        32'h0,        1'b0};
      vecs[5] = '{1'b1, 1'b0, 24'hABCDEF, 32'h2222,     32'hCAFEF00D, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 24'h800000, 32'h3333,     32'h0,        1'b0};

      // Reset state, with both requests already high for the contention run.
      drive(0, 1, 1, 24'h000111, 32'hA0A0A0A0);
      drive(1, 1, 0, 24'h000222, 32'h5);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gb_we", u0_gb_we, 0);
      chk("rst_gb_re", u0_gb_re, 0);
      chk("rst_done", {u0_m0_done, u0_m1_done}, 0);
      chk("rst_busy", u0_busy, 0);
      chk("rst_gb_addr", u0_gb_addr, 0);
      chk("rst_gb_wdata", u0_gb_wdata, 0);
      chk("rst_rdata", {u0_m0_rdata, u0_m1_rdata}, 0);
      chk("rst_last_grant", u0_last_grant, 1);
      chk("rst_l1_last_grant", l1_last_grant, 1);
      chk("rst_l1_busy", l1_busy, 0);

      // Continuous contention out of reset: m0 write, m1 read, alternating.
      @(posedge clk); #1;
      rst_n = 1;
      t = cyc;
      sb.push_back(mk(0, 1, 24'h000111, 32'hA0A0A0A0, 32'h0,        t + 1));
      sb.push_back(mk(1, 0, 24'h000222, 32'h5,        32'h11110001, t + 4));
      sb.push_back(mk(0, 1, 24'h000111, 32'hA0A0A0A0, 32'h0,        t + 9));
      sb.push_back(mk(1, 0, 24'h000222, 32'h5,        32'h22220002, t + 12));
      n = 0;
      for (int k = 0; k < 60 && n < 4; k++) begin
         @(negedge clk);
         if (u0_m0_done || u0_m1_done) n++;
      end
      drive(0, 0, 0, 24'h0, 32'h0);
      drive(1, 0, 0, 24'h0, 32'h0);
      chk("contention_dones", n, 4);
      @(negedge clk);
      chk("contention_sb_empty", sb.size(), 0);

      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         drive(vecs[i].port, 1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
         sb.push_back(mk(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                         vecs[i].rdata, cyc + 1));
         @(negedge clk);
         chk("busy_before_strobe", u0_busy, 0);
         @(posedge clk); #1;
         drive(vecs[i].port, 1, ~vecs[i].we, ~vecs[i].addr, ~vecs[i].wdata);
         ok = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (vecs[i].port ? u0_m1_done : u0_m0_done) begin ok = 1; break; end
         end
         chk("vec_done_seen", ok, 1);
         @(posedge clk); #1;
         drive(vecs[i].port, 0, 0, 24'h0, 32'h0);
         @(negedge clk);
         chk("vec_idle_busy", u0_busy, 0);
         chk("vec_done_one_cycle", u0_m0_done | u0_m1_done, 0);
         chk("vec_last_grant", u0_last_grant, vecs[i].exp_lg);
         chk("vec_gb_addr_hold", u0_gb_addr, vecs[i].addr);
         chk("vec_gb_wdata_hold", u0_gb_wdata, vecs[i].wdata);
         chk("vec_rdata_hold", vecs[i].port ? u0_m1_rdata : u0_m0_rdata,
             exp_rd[vecs[i].port]);
      end

      // m0 read with its request dropped during WAIT.
      @(posedge clk); #1;
      drive(0, 1, 0, 24'h000055, 32'h0);
      sb.push_back(mk(0, 0, 24'h000055, 32'h0, 32'h600DF00D, cyc + 1));
      wait_strobe();
      @(posedge clk); #1;
      drive(0, 0, 0, 24'h0, 32'h0);
      ok = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (u0_m0_done) begin ok = 1; break; end
      end
      chk("drop_done_seen", ok, 1);
      chk("drop_rdata", u0_m0_rdata, 32'h600DF00D);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("drop_no_strobe", u0_gb_we | u0_gb_re, 0);
      end
      chk("drop_idle", u0_busy, 0);

      // Reset in the WAIT cycle of an m1 read.
      @(posedge clk); #1;
      drive(1, 1, 0, 24'h000077, 32'h0);
      sb.push_back(mk(1, 0, 24'h000077, 32'h0, 32'h77777777, cyc + 1));
      wait_strobe();
      @(posedge clk); #1;
      rst_n = 0;
      sb.delete();
      exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
      u0_pend = 0;
      drive(1, 0, 0, 24'h0, 32'h0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      chk("midrst_busy", u0_busy, 0);
      chk("midrst_rdata", {u0_m0_rdata, u0_m1_rdata}, 0);
      chk("midrst_gb_addr", u0_gb_addr, 0);
      for (int k = 0; k < 4; k++) begin
         chk("midrst_no_done", u0_m0_done | u0_m1_done, 0);
         @(negedge clk);
      end

      // RD_LAT=1: two back-to-back reads from m0 with the request held.
      @(posedge clk); #1;
      l1_m0_req = 1;
      t = cyc; ns = 0; nd = 0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (l1_gb_re && ns < 4) begin st[ns] = cyc; ns++; end
         if (l1_m0_done && nd < 4) begin
            dn[nd] = cyc;
            chk("l1_rdata", l1_m0_rdata, 32'hC0DE_0000 ^ 32'(st[nd]));
            nd++;
            if (nd == 2) l1_m0_req = 0;
         end
      end
      chk("l1_strobes", ns, 2);
      chk("l1_dones", nd, 2);
      if (ns == 2 && nd == 2) begin
         chk("l1_strobe0", st[0], t + 1);
         chk("l1_done0", dn[0], t + 3);
         chk("l1_spacing", st[1] - st[0], 4);
         chk("l1_done1", dn[1], t + 7);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gb_host_arbiter.md
Name: gb_host_arbiter

Overview:
- Shares one ghostbus host port between two requesters, m0 and m1.
- Typical pairing: an external host bridge on one side and an on-chip sequencer (e.g. a config loader) on the other. Both need access to the host-accessible registers and RAMs decoded downstream.
- Each transaction is a single read or write. Ties are broken round-robin. Read data returns after a fixed pipeline latency.

Parameters:
AW, 24, address width of the ghostbus and requester address ports
DW, 32, data width of the ghostbus and requester data ports
RD_LAT, 2, cycles from gb_re strobe to valid gb_rdata; legal range 1..15

Ports:
- Clocking and reset:
  - clk  in  1  system clock; all logic on rising edge
  - rst_n  in  1  synchronous reset, active low
- Requester m0:
  - m0_req  in  1  transaction request; held until m0_done
  - m0_we  in  1  1=write, 0=read
  - m0_addr  in  AW  target address
  - m0_wdata  in  DW  write data
  - m0_done  out  1  one-cycle completion pulse
  - m0_rdata  out  DW  read data; valid when m0_done pulses after a read
- Requester m1: m1_req, m1_we, m1_addr, m1_wdata, m1_done, m1_rdata, identical to m0.
- Ghostbus host side:
  - gb_addr  out  AW  ghostbus address
  - gb_wdata  out  DW  ghostbus write data
  - gb_we  out  1  one-cycle write strobe
  - gb_re  out  1  one-cycle read strobe
  - gb_rdata  in  DW  read data, valid RD_LAT cycles after gb_re
- Status:
  - busy  out  1  high whenever FSM is not IDLE
  - last_grant  out  1  index of the most recently granted requester

Behaviour:
- Reset (rst_n low at a rising edge):
  - FSM goes to IDLE; latency counter clears.
  - gb_we, gb_re, m0_done, m1_done, busy = 0.
  - gb_addr, gb_wdata, m0_rdata, m1_rdata = 0.
  - last_grant = 1, so m0 wins the first tie.
- FSM states: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - Requests are sampled at each rising edge.
  - One req high: grant that requester.
  - Both high: grant ~last_grant.
  - On grant: capture we/addr/wdata of the winner into gb_addr/gb_wdata and an internal we flag; update last_grant; go to STROBE.
- STROBE: exactly one cycle.
  - gb_we=1 if write, else gb_re=1. gb_addr and gb_wdata are valid in the same cycle.
  - Next state: write goes to DONE; read loads the counter with RD_LAT and goes to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the strobe was in cycle S, gb_rdata is captured into the granted port's rdata register at the edge ending cycle S+RD_LAT. The FSM then goes to DONE.
- DONE: exactly one cycle. The granted port's done = 1; then the FSM returns to IDLE.
- Latency, with the grant sampled at the edge ending cycle T:
  - Strobe in T+1.
  - Write done in T+2.
  - Read done in T+2+RD_LAT.
  - Minimum write issue spacing is 3 cycles; read spacing is 3+RD_LAT cycles.
- Signal hold rules:
  - gb_we and gb_re are never high together. Each is high for at most one cycle per transaction.
  - gb_addr and gb_wdata hold their last value between transactions.
  - mX_rdata holds its value until that port's next read completes; writes never modify it.
  - m0_done and m1_done are never high together.
- Requester protocol:
  - A requester may deassert req in the cycle after done. If req is still high in the cycle after done, that is a new transaction.
  - Requester inputs that change after the grant are ignored.
  - If req is dropped mid-transaction, the transaction still completes and done still pulses.
- Fairness: under continuous contention from both requesters, grants strictly alternate.
- Reset mid-transaction: the FSM aborts immediately. No done pulse is issued and in-flight read data is discarded. Downstream side effects of an already issued strobe stand.
- Counter width is 4 bits. RD_LAT=1 is legal; RD_LAT=0 is unsupported.

Test Plan:
- Write: m0 writes addr 0x000010, data 0xDEADBEEF.
  - Required: gb_we=1 for one cycle at T+1 with gb_addr=0x000010 and gb_wdata=0xDEADBEEF.
  - m0_done pulses at T+2; m1_done stays 0; busy is high T+1..T+2.
- Read, RD_LAT=2: m1 reads 0x000040; bench drives gb_rdata=0x5 exactly 2 cycles after gb_re.
  - Required: m1_done at T+4 with m1_rdata=0x5; m0_rdata unchanged.
- Contention: both req held high continuously, out of reset.
  - Required grant order m0, m1, m0, m1. last_grant toggles 0,1,0,1. No back-to-back done pulses to the same port.
- Drop mid-transaction: m0 read request, m0_req dropped during WAIT.
  - Required: m0_done still pulses and rdata is captured. The FSM then idles with no further strobe.
- Reset mid-read: rst_n low in the WAIT cycle.
  - Required: next cycle state is IDLE, busy=0, no done pulse, and m0_rdata/m1_rdata read 0.
- RD_LAT=1 build: single read.
  - Required: done at T+3. The same read repeated with req held high gives strobes spaced 4 cycles apart.
